mult_seq_controller_taint: RTL and testbench
============================================

Name: mult_seq_controller_taint

Overview:
- FSM controller that sequences the taint-tracking shift-add multiplier datapath.
- Drives the load, clear, add and shift strobes, each paired with a taint bit.
- Accepts a start/done handshake from the host.
- Tracks control-flow taint so that any strobe or completion timing influenced by tainted data or a tainted start is flagged tainted.

Parameters:
- WIDTH, 2048, operand width; must match the datapath WIDTH.
- EARLY_SKIP, 0, 1 = skip the add cycle for zero multiplier bits (variable time); 0 = constant time.
- IDXW, $clog2(WIDTH), bit-index counter width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  host request to begin a multiplication.
- start_t  input  1  taint of start.
- multiplierReg  input  WIDTH  multiplier register value fed back from the datapath.
- multiplierReg_t  input  WIDTH  taint of multiplierReg.
- mrld, mdld, rsclear, rsload, rsshr  output  1 each  datapath strobes.
- mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t  output  1 each  strobe taints.
- busy  output  1  high from LOAD through the final SHIFT.
- done  output  1  one-cycle pulse; product is valid on the datapath.
- done_t  output  1  taint of done and of its timing.
- bit_idx  output  IDXW  multiplier bit currently being processed (debug).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bit_idx=0, ctl_t=0. All strobes, strobe taints, busy, done and done_t are 0.
- Reset asserted mid-operation aborts immediately. No resume.
- States: IDLE, LOAD, ADD, SHIFT, DONE. All strobes are Moore outputs of registered state, except rsload, which also depends on multiplierReg[bit_idx].
- IDLE:
  - All strobes 0.
  - start=1 at an edge -> LOAD, and ctl_t <= start_t (this clears stale taint).
  - start while in any other state is ignored. start_t is ignored whenever start is not accepted.
- LOAD (1 cycle):
  - mrld=mdld=rsclear=1, busy=1, bit_idx <= 0.
  - Next state is always ADD, because multiplierReg is not yet valid during LOAD.
- ADD (1 cycle): rsload=multiplierReg[bit_idx], rsshr=0, busy=1. Next state is SHIFT.
- SHIFT (1 cycle): rsshr=1, busy=1.
  - If bit_idx==WIDTH-1 -> DONE.
  - Else bit_idx <= bit_idx+1, then:
    - if EARLY_SKIP=1 and multiplierReg[bit_idx+1]==0 -> SHIFT;
    - otherwise -> ADD.
- DONE (1 cycle): done=1, busy=0, then IDLE. The next start is accepted in the following IDLE cycle at the earliest.
- Latency:
  - EARLY_SKIP=0: done goes high exactly 2*WIDTH+2 cycles after the start-sampling edge, independent of data.
  - EARLY_SKIP=1: 2*WIDTH+2 minus the number of zero bits in multiplierReg[WIDTH-1:1].
- Taint rules (ctl_t is a sticky register):
  - Every strobe _t output and done_t equal ctl_t in every state, including when the strobe is deasserted.
  - Exception: in ADD, rsload_t = ctl_t | multiplierReg_t[bit_idx].
  - EARLY_SKIP=1: in SHIFT with bit_idx<WIDTH-1, ctl_t <= ctl_t | multiplierReg_t[bit_idx+1], because the branch depends on that bit.
  - EARLY_SKIP=0: ctl_t never changes after start is accepted.
  - ctl_t is cleared only by reset or by accepting a new start.
- Width rule: bit_idx never exceeds WIDTH-1. The terminal test uses equality to WIDTH-1; there is no wrap.
- Datapath hookup: the strobes drive the datapath directly. Product is read on the datapath outputs when done=1.

Test Plan:
1. WIDTH=4, EARLY_SKIP=0, multiplier=4'b1011, multiplicand=5, no taint, start for 1 cycle -> rsload pattern 1,1,0,1; done 10 cycles after the start edge; product=55; all _t=0.
2. Same operands with EARLY_SKIP=1 -> only bit2 is skipped, so done comes 9 cycles after the start edge; product=55; done_t=0.
3. EARLY_SKIP=1, multiplierReg_t=4'b0100 -> ctl_t sets in the SHIFT with bit_idx=1. rsload_t, rsshr_t and done_t are 1 from the next cycle onward, and 0 before it.
4. EARLY_SKIP=0, same taint -> rsload_t=1 only in ADD with bit_idx=2; done_t=0; timing is identical to scenario 1.
5. start_t=1 with start -> every _t output is 1 through DONE. A second start with start_t=0 -> all _t outputs return to 0.
6. Mid-run checks:
   - Assert rst_n=0 during ADD with bit_idx=2 -> outputs drop to 0 asynchronously; state IDLE after release.
   - start pulsed while busy -> ignored; exactly one done.

Source files
------------

// File: rtl/mult_seq_controller_taint_if.sv
// Handshake/strobe bundle between host/datapath and the multiplier controller.
// Host/datapath side uses master; the controller uses slave.
//   start/start_t                 : host request and its taint
//   multiplierReg/multiplierReg_t : multiplier value and taint from datapath
//   mrld..rsshr (+ _t)            : datapath strobes and their taints
//   busy/done/done_t/bit_idx      : status back to host
interface mult_seq_controller_taint_if #(
    parameter int WIDTH = 2048,
    parameter int IDXW  = $clog2(WIDTH)
);
    logic             start;
    logic             start_t;
    logic [WIDTH-1:0] multiplierReg;
    logic [WIDTH-1:0] multiplierReg_t;
    logic             mrld;
    logic             mdld;
    logic             rsclear;
    logic             rsload;
    logic             rsshr;
    logic             mrld_t;
    logic             mdld_t;
    logic             rsclear_t;
    logic             rsload_t;
    logic             rsshr_t;
    logic             busy;
    logic             done;
    logic             done_t;
    logic [IDXW-1:0]  bit_idx;

    modport master (
        output start, start_t, multiplierReg, multiplierReg_t,
        input  mrld, mdld, rsclear, rsload, rsshr,
        input  mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
        input  busy, done, done_t, bit_idx
    );

    modport slave (
        input  start, start_t, multiplierReg, multiplierReg_t,
        output mrld, mdld, rsclear, rsload, rsshr,
        output mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
        output busy, done, done_t, bit_idx
    );
endinterface

// File: rtl/mult_seq_controller_taint.sv
// Sequencer for the taint-tracking shift-add multiplier datapath.
// Ports: clk, rst_n (async, active low), bus (slave side of the bundle).
module mult_seq_controller_taint #(
    parameter int WIDTH      = 2048,
    parameter int EARLY_SKIP = 0,
    parameter int IDXW       = $clog2(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mult_seq_controller_taint_if.slave   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

    logic [2:0]      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            ctl_t_q, ctl_t_d;
    logic [IDXW-1:0] idx_nxt;

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ctl_t_d = ctl_t_q;
        case (state_q)
            S_IDLE: begin
                // accepting a start discards taint left by the previous run
                if (bus.start) begin
                    state_d = S_LOAD;
                    ctl_t_d = bus.start_t;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                // multiplierReg is loaded this cycle, so bit 0 always gets an ADD
                idx_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_nxt;
                    state_d = S_ADD;
                    if (EARLY_SKIP != 0) begin
                        // the branch reveals the next bit, so its taint
                        // leaks into all later timing
                        ctl_t_d = ctl_t_q | bus.multiplierReg_t[idx_nxt];
                        if (!bus.multiplierReg[idx_nxt]) begin
                            state_d = S_SHIFT;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ctl_t_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ctl_t_q <= ctl_t_d;
        end
    end

    logic in_load, in_add, in_shift, in_done;

    assign in_load  = (state_q == S_LOAD);
    assign in_add   = (state_q == S_ADD);
    assign in_shift = (state_q == S_SHIFT);
    assign in_done  = (state_q == S_DONE);

    assign bus.mrld    = in_load;
    assign bus.mdld    = in_load;
    assign bus.rsclear = in_load;
    assign bus.rsload  = in_add & bus.multiplierReg[idx_q];
    assign bus.rsshr   = in_shift;
    assign bus.busy    = in_load | in_add | in_shift;
    assign bus.done    = in_done;
    assign bus.bit_idx = idx_q;

    // taints follow ctl_t even while the strobe itself is low
    assign bus.mrld_t    = ctl_t_q;
    assign bus.mdld_t    = ctl_t_q;
    assign bus.rsclear_t = ctl_t_q;
    assign bus.rsshr_t   = ctl_t_q;
    assign bus.done_t    = ctl_t_q;
    assign bus.rsload_t  = ctl_t_q
                         | (in_add & bus.multiplierReg_t[idx_q]);

endmodule

// File: tb/tb_mult_seq_controller_taint.sv
// Bench for mult_seq_controller_taint: EARLY_SKIP=0 and =1 side by side.
// Per-cycle comparison against a queue of expected output vectors.
module tb_mult_seq_controller_taint;

    localparam int W  = 4;
    localparam int IW = 2;
    localparam int PW = 2 * W + 1;

    typedef struct packed {
        logic          mrld;
        logic          mdld;
        logic          rsclear;
        logic          rsload;
        logic          rsshr;
        logic          busy;
        logic          done;
        logic          mrld_t;
        logic          mdld_t;
        logic          rsclear_t;
        logic          rsload_t;
        logic          rsshr_t;
        logic          done_t;
        logic          chk_idx;
        logic [IW-1:0] idx;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         start_t = 1'b0;
    logic [W-1:0] mreg = '0;
    logic [W-1:0] mreg_t = '0;
    logic [W-1:0] md = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    exp_t     q [2][$];
    logic     idle_t [2];
    int       done_cyc [2];
    int       ndone [2];
    logic     dt_seen [2];
    logic [PW-1:0] P [2];
    logic [2*W-1:0] prod_seen [2];
    int       lat_r [2];

    always #5 clk = ~clk;

    mult_seq_controller_taint_if #(.WIDTH(W), .IDXW(IW)) if0 ();
    mult_seq_controller_taint_if #(.WIDTH(W), .IDXW(IW)) if1 ();

    assign if0.start = start;
    assign if0.start_t = start_t;
    assign if0.multiplierReg = mreg;
    assign if0.multiplierReg_t = mreg_t;
    assign if1.start = start;
    assign if1.start_t = start_t;
    assign if1.multiplierReg = mreg;
    assign if1.multiplierReg_t = mreg_t;

    mult_seq_controller_taint #(
        .WIDTH(W), .EARLY_SKIP(0), .IDXW(IW)
    ) u_ct (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );

    mult_seq_controller_taint #(
        .WIDTH(W), .EARLY_SKIP(1), .IDXW(IW)
    ) u_es (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    exp_t act [2];

    assign act[0] = {if0.mrld, if0.mdld, if0.rsclear, if0.rsload,
                     if0.rsshr, if0.busy, if0.done, if0.mrld_t,
                     if0.mdld_t, if0.rsclear_t, if0.rsload_t,
                     if0.rsshr_t, if0.done_t, 1'b0, if0.bit_idx};
    assign act[1] = {if1.mrld, if1.mdld, if1.rsclear, if1.rsload,
                     if1.rsshr, if1.busy, if1.done, if1.mrld_t,
                     if1.mdld_t, if1.rsclear_t, if1.rsload_t,
                     if1.rsshr_t, if1.done_t, 1'b0, if1.bit_idx};

    always @(posedge clk) cyc <= cyc + 1;

    // shift-add datapath driven by the DUT strobes
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (act[k].rsclear)
                P[k] <= '0;
            else if (act[k].rsload)
                P[k] <= P[k] + (PW'(md) << W);
            else if (act[k].rsshr)
                P[k] <= P[k] >> 1;
        end
    end

    function automatic exp_t mk(logic c);
        exp_t e;
        e = '0;
        e.mrld_t = c;
        e.mdld_t = c;
        e.rsclear_t = c;
        e.rsload_t = c;
        e.rsshr_t = c;
        e.done_t = c;
        return e;
    endfunction

    // expected cycle-by-cycle outputs of one run, from start acceptance on
    task automatic push_run(int k, logic [W-1:0] mr,
                            logic [W-1:0] mrt, logic st, bit early);
        logic c;
        exp_t e;
        c = st;
        e = mk(c);
        e.mrld = 1; e.mdld = 1; e.rsclear = 1; e.busy = 1;
        q[k].push_back(e);
        for (int i = 0; i < W; i++) begin
            if (!early || i == 0 || mr[i]) begin
                e = mk(c);
                e.rsload = mr[i];
                e.rsload_t = c | mrt[i];
                e.busy = 1; e.chk_idx = 1; e.idx = IW'(i);
                q[k].push_back(e);
            end
            e = mk(c);
            e.rsshr = 1; e.busy = 1; e.chk_idx = 1; e.idx = IW'(i);
            q[k].push_back(e);
            if (early && i < W - 1) c = c | mrt[i+1];
        end
        e = mk(c);
        e.done = 1;
        q[k].push_back(e);
        idle_t[k] = c;
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        for (int k = 0; k < 2; k++) begin
            if (rst_n && act[k].done) begin
                done_cyc[k] = cyc;
                dt_seen[k] = act[k].done_t;
                prod_seen[k] = P[k][2*W-1:0];
                ndone[k]++;
            end
            if (chk_en) begin
                if (q[k].size() > 0) e = q[k].pop_front();
                else e = mk(idle_t[k]);
                a = act[k];
                a.chk_idx = e.chk_idx;
                if (!e.chk_idx) a.idx = e.idx;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle inst%0d cyc=%0d actual %h required %h",
                             k, cyc, a, e);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] a, logic [31:0] r);
        checks++;
        if (a !== r) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, a, r);
        end
    endtask

    task automatic do_run(logic [W-1:0] mr, logic [W-1:0] mrt,
                          logic st, logic [W-1:0] mdv, bit pulse);
        int sc;
        int nd [2];
        int z;
        bit busy_q;
        @(posedge clk); #1;
        start = 1; start_t = st;
        mreg = mr; mreg_t = mrt; md = mdv;
        @(posedge clk); #1;
        start = 0; start_t = 1'($urandom);
        sc = cyc;
        nd[0] = ndone[0]; nd[1] = ndone[1];
        push_run(0, mr, mrt, st, 1'b0);
        push_run(1, mr, mrt, st, 1'b1);
        if (pulse) begin
            repeat (2) @(posedge clk);
            #1 start = 1; start_t = 1'($urandom);
            @(posedge clk); #1 start = 0;
        end
        busy_q = 1;
        for (int n = 0; n < 200 && busy_q; n++) begin
            @(posedge clk);
            busy_q = (q[0].size() > 0) || (q[1].size() > 0);
        end
        #1;
        chk("run_timeout", 32'(busy_q), 0);
        // latency counts the start edge and the done edge inclusively
        z = 0;
        for (int i = 1; i < W; i++) if (!mr[i]) z++;
        for (int k = 0; k < 2; k++) begin
            lat_r[k] = done_cyc[k] - sc + 1;
            chk("one_done", 32'(ndone[k] - nd[k]), 1);
            chk("product", 32'(prod_seen[k]), 32'(mr * mdv));
        end
        chk("lat_const", 32'(lat_r[0]), 32'(2 * W + 2));
        chk("lat_skip", 32'(lat_r[1]), 32'(2 * W + 2 - z));
    endtask

    initial begin
        logic [W-1:0] r_mr, r_mrt, r_md;
        logic r_st;
        for (int k = 0; k < 2; k++) begin
            idle_t[k] = 0; ndone[k] = 0; done_cyc[k] = 0;
            dt_seen[k] = 0; P[k] = '0;
        end
        #1;
        chk("reset_ct", 32'(act[0]), 0);
        chk("reset_es", 32'(act[1]), 0);
        #12 rst_n = 1;
        @(posedge clk); #1 chk_en = 1;

        // 1011 x 5, no taint; also a start pulse while busy
        do_run(4'b1011, 4'b0000, 0, 4'd5, 1);
        chk("s1_lat_ct", 32'(lat_r[0]), 10);
        chk("s2_lat_es", 32'(lat_r[1]), 9);
        chk("s1_prod", 32'(prod_seen[0]), 55);
        chk("s2_prod", 32'(prod_seen[1]), 55);
        chk("s1_done_t", 32'(dt_seen[0]), 0);
        chk("s2_done_t", 32'(dt_seen[1]), 0);

        // bit 2 tainted: only the skipping variant taints timing
        do_run(4'b1011, 4'b0100, 0, 4'd5, 0);
        chk("s3_done_t", 32'(dt_seen[1]), 1);
        chk("s4_done_t", 32'(dt_seen[0]), 0);
        chk("s4_lat", 32'(lat_r[0]), 10);

        // tainted start, then a clean start clears it
        do_run(4'b0110, 4'b0000, 1, 4'd9, 0);
        chk("s5_done_t_ct", 32'(dt_seen[0]), 1);
        chk("s5_done_t_es", 32'(dt_seen[1]), 1);
        do_run(4'b0110, 4'b0000, 0, 4'd9, 0);
        chk("s5_clear_ct", 32'(dt_seen[0]), 0);
        chk("s5_clear_es", 32'(dt_seen[1]), 0);

        for (int n = 0; n < 24; n++) begin
            r_mr = W'($urandom);
            r_mrt = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
            r_st = ($urandom_range(0, 3) == 0);
            r_md = W'($urandom);
            do_run(r_mr, r_mrt, r_st, r_md, 1'($urandom));
        end

        // asynchronous abort during ADD of bit 2
        @(posedge clk); #1;
        chk_en = 0;
        start = 1; start_t = 1;
        mreg = 4'b1111; mreg_t = 4'b1111;
        @(posedge clk); #1 start = 0;
        repeat (5) @(posedge clk);
        #2;
        chk("abort_idx_ct", 32'(act[0].idx), 2);
        chk("abort_idx_es", 32'(act[1].idx), 2);
        chk("abort_add_ct", 32'(act[0].rsload), 1);
        rst_n = 0;
        #1;
        chk("abort_zero_ct", 32'(act[0]), 0);
        chk("abort_zero_es", 32'(act[1]), 0);
        #3 rst_n = 1;
        q[0].delete(); q[1].delete();
        idle_t[0] = 0; idle_t[1] = 0;
        @(posedge clk); #1 chk_en = 1;
        repeat (3) @(posedge clk);
        do_run(4'b1101, 4'b0000, 0, 4'd11, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
